// File: rtl/alu4_pkg.sv
// alu4_pkg: shared types and constants for the 4-bit ALU issue sequencer
package alu4_pkg;
    localparam int IMM_W = 4;
    localparam int OPC_W = 4;
    localparam int FLAG_C = 0;
    localparam int FLAG_R = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 3;
    typedef enum logic [1:0] {EXEC_I = 2'b00, EXEC_B = 2'b01, LDA = 2'b10, MOVB = 2'b11} mode_e;
    typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_e;
    typedef struct packed {
        mode_e             mode;
        logic [OPC_W-1:0]  opcode;
        logic [IMM_W-1:0]  imm;
    } instr_t;
endpackage

// File: rtl/alu4_instr_fifo.sv
// alu4_instr_fifo: synchronous FIFO with wrapping pointers and a separate occupancy count
module alu4_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    always_comb begin
        full = cnt_q == (AW+1)'(DEPTH);
        empty = cnt_q == '0;
        do_push = push && !full;
        do_pop = pop && !empty;
        wr_d = wr_q + AW'(do_push);
        rd_d = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !clr && !rst) mem[wr_q] <= din;
    end
    assign dout = mem[rd_q];
    assign count = cnt_q;
endmodule

// File: rtl/alu4_issue_seq.sv
// alu4_issue_seq: buffers instructions, drives the combinational ALU and commits its results
module alu4_issue_seq
    import alu4_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W = 4,
    parameter int OP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_cin,
    output logic              alu_rin,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_cout,
    input  logic              alu_rout,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    output logic [DATA_W-1:0] acc_out,
    output logic [DATA_W-1:0] breg_out,
    output logic [3:0]        flags_out,
    output logic              retire,
    output logic              busy
);
    state_e                    state_q, state_d;
    instr_t                    ir_q, ir_d, fifo_dout, fifo_din;
    logic [DATA_W-1:0]         acc_q, acc_d, breg_q, breg_d;
    logic [3:0]                flags_q, flags_d, alu_flags;
    logic                      retire_q, retire_d;
    logic                      exec, commit, pop, is_exec_mode;
    logic                      fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    assign fifo_din = '{mode: mode_e'(in_mode), opcode: in_opcode, imm: in_imm};
    alu4_instr_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(instr_t))) u_fifo (
        .clk(clk), .rst(rst), .clr(flush), .push(in_valid && !flush), .pop(pop),
        .din(fifo_din), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
    );
    always_comb begin
        exec = state_q == EXEC;
        commit = exec && !flush;
        pop = state_q == FETCH && !fifo_empty && !flush;
        is_exec_mode = ir_q.mode == EXEC_I || ir_q.mode == EXEC_B;
        alu_flags = '0;
        alu_flags[FLAG_C] = alu_cout;
        alu_flags[FLAG_R] = alu_rout;
        alu_flags[FLAG_Z] = alu_zero;
        alu_flags[FLAG_V] = alu_ovf;
        state_d = pop ? EXEC : FETCH;
        ir_d = pop ? fifo_dout : ir_q;
        acc_d = (!commit || ir_q.mode == MOVB) ? acc_q : ir_q.mode == LDA ? ir_q.imm : alu_out;
        breg_d = (commit && ir_q.mode == MOVB) ? acc_q : breg_q;
        flags_d = (commit && is_exec_mode) ? alu_flags : flags_q;
        retire_d = commit;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            ir_q <= '0;
            acc_q <= '0;
            breg_q <= '0;
            flags_q <= '0;
            retire_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q <= ir_d;
            acc_q <= acc_d;
            breg_q <= breg_d;
            flags_q <= flags_d;
            retire_q <= retire_d;
        end
    end
    assign alu_a = acc_q;
    assign alu_b = exec ? (ir_q.mode == EXEC_B ? breg_q : ir_q.imm) : '0;
    assign alu_op = exec ? ir_q.opcode : '0;
    assign alu_cin = flags_q[FLAG_C];
    assign alu_rin = flags_q[FLAG_R];
    assign acc_out = acc_q;
    assign breg_out = breg_q;
    assign flags_out = flags_q;
    assign retire = retire_q;
    assign busy = fifo_count != '0 || exec;
    assign in_ready = !fifo_full;
endmodule

// File: tb/tb_alu4_issue_seq.sv
// tb_alu4_issue_seq: randomized and directed scoreboard bench with an adder-style ALU stub
module tb_alu4_issue_seq;
    logic       clk = 0, rst = 1, flush = 0, in_valid = 0;
    logic       in_ready, alu_cin, alu_rin, retire, busy;
    logic [1:0] in_mode = 0;
    logic [3:0] in_opcode = 0, in_imm = 0;
    logic [3:0] alu_a, alu_b, alu_op, alu_out, acc_out, breg_out, flags_out;
    logic       alu_cout, alu_rout, alu_zero, alu_ovf;
    logic [4:0] sum;
    typedef struct {logic [3:0] acc; logic [3:0] breg; logic [3:0] flags;} exp_t;
    exp_t exp_q[$];
    logic [3:0] spec_acc = 0, spec_breg = 0, spec_flags = 0;
    logic [3:0] com_acc = 0, com_breg = 0, com_flags = 0;
    int total = 0, bad = 0, stall_cnt = 0;

    alu4_issue_seq dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_opcode(in_opcode), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin), .alu_rin(alu_rin),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_rout(alu_rout), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .acc_out(acc_out), .breg_out(breg_out), .flags_out(flags_out), .retire(retire), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        alu_out = sum[3:0];
        alu_cout = sum[4];
        alu_rout = alu_a[3];
        alu_zero = sum[3:0] == 4'h0;
        alu_ovf = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each accepted instruction is applied in program order to a speculative state.
    task automatic accept(input logic [1:0] m, input logic [3:0] imm);
        int sa, sb, sr, u;
        logic [3:0] b;
        if (m == 2'b10) spec_acc = imm;
        else if (m == 2'b11) spec_breg = spec_acc;
        else begin
            b = (m == 2'b00) ? imm : spec_breg;
            u = int'(spec_acc) + int'(b) + int'(spec_flags[0]);
            sa = spec_acc[3] ? int'(spec_acc) - 16 : int'(spec_acc);
            sb = b[3] ? int'(b) - 16 : int'(b);
            sr = sa + sb + int'(spec_flags[0]);
            spec_flags = {sr > 7 || sr < -8, (u % 16) == 0, spec_acc[3], u > 15};
            spec_acc = 4'(u % 16);
        end
        exp_q.push_back('{spec_acc, spec_breg, spec_flags});
    endtask

    task automatic issue(input logic [1:0] m, input logic [3:0] op, input logic [3:0] imm);
        bit ok = 0;
        in_valid = 1; in_mode = m; in_opcode = op; in_imm = imm;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (exp_q.size() >= 5) chk("ready_when_full", int'(in_ready), 0);
            if (exp_q.size() <= 3) chk("ready_when_room", int'(in_ready), 1);
            if (in_ready) begin accept(m, imm); ok = 1; end
            else stall_cnt++;
            @(negedge clk);
        end
        if (!ok) chk("issue_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic wait_op(input logic [3:0] op);
        bit hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (alu_op == op) hit = 1;
            else @(negedge clk);
        end
        if (!hit) chk("wait_exec_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (!busy && exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_idle", int'(busy), 0);
        chk("drain_sb_empty", exp_q.size(), 0);
    endtask

    task automatic model_clear(input bit zero);
        exp_q.delete();
        if (zero) begin com_acc = 0; com_breg = 0; com_flags = 0; end
        spec_acc = com_acc; spec_breg = com_breg; spec_flags = com_flags;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (retire === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_retire", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_acc", int'(acc_out), int'(e.acc));
                    chk("sb_breg", int'(breg_out), int'(e.breg));
                    chk("sb_flags", int'(flags_out), int'(e.flags));
                    com_acc = e.acc; com_breg = e.breg; com_flags = e.flags;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_acc", int'(acc_out), 0);
        chk("rst_breg", int'(breg_out), 0);
        chk("rst_flags", int'(flags_out), 0);
        chk("rst_retire", int'(retire), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_alu_op", int'(alu_op), 0);
        chk("rst_alu_b", int'(alu_b), 0);

        issue(2'b10, 4'h0, 4'h9);
        @(posedge clk);
        @(posedge clk); #2;
        chk("lda_latency_retire", int'(retire), 1);
        chk("lda_acc", int'(acc_out), 9);
        chk("lda_flags", int'(flags_out), 0);
        @(posedge clk); #2;
        chk("lda_retire_pulse", int'(retire), 0);
        chk("lda_busy_fall", int'(busy), 0);
        @(negedge clk);

        issue(2'b10, 4'h0, 4'h7);
        issue(2'b11, 4'h0, 4'h0);
        issue(2'b10, 4'h0, 4'h9);
        issue(2'b01, 4'h5, 4'h0);
        wait_op(4'h5);
        chk("execb_alu_a", int'(alu_a), 9);
        chk("execb_alu_b", int'(alu_b), 7);
        drain();
        chk("execb_breg", int'(breg_out), 7);
        chk("execb_acc", int'(acc_out), 0);
        chk("execb_flags", int'(flags_out), 4'b0111);

        stall_cnt = 0;
        for (int i = 0; i < 8; i++) issue(2'(i % 4), 4'h0, 4'(i * 3 + 1));
        chk("burst_stalled", int'(stall_cnt > 0), 1);
        drain();

        issue(2'b10, 4'h0, 4'hF);
        issue(2'b00, 4'h3, 4'h1);
        issue(2'b00, 4'h6, 4'h0);
        wait_op(4'h6);
        chk("carry_cin", int'(alu_cin), 1);
        chk("carry_alu_a", int'(alu_a), 0);
        chk("carry_rin", int'(alu_rin), int'(com_flags[1]));
        drain();
        chk("carry_acc", int'(acc_out), 1);

        issue(2'b10, 4'h0, 4'h4);
        drain();
        issue(2'b00, 4'hA, 4'h3);
        issue(2'b00, 4'hA, 4'h3);
        issue(2'b00, 4'hA, 4'h3);
        wait_op(4'hA);
        flush = 1; in_valid = 1; in_mode = 2'b10; in_imm = 4'hE;
        model_clear(0);
        @(negedge clk);
        flush = 0; in_valid = 0;
        chk("flush_no_retire", int'(retire), 0);
        chk("flush_acc_kept", int'(acc_out), int'(com_acc));
        chk("flush_busy", int'(busy), 0);
        chk("flush_ready", int'(in_ready), 1);
        repeat (3) @(negedge clk);
        chk("flush_push_dropped", int'(busy), 0);

        issue(2'b11, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) issue(2'b00, 4'hA, 4'h5);
        wait_op(4'hA);
        rst = 1;
        model_clear(1);
        @(negedge clk);
        rst = 0;
        chk("midrst_acc", int'(acc_out), 0);
        chk("midrst_breg", int'(breg_out), 0);
        chk("midrst_flags", int'(flags_out), 0);
        chk("midrst_retire", int'(retire), 0);
        chk("midrst_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);

        for (int i = 0; i < 60; i++) begin
            issue(2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), 4'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
